irq_ctrl: RTL and testbench

- Memory-mapped interrupt controller that sits directly upstream of the CPU core.
- Synchronises four external event inputs and latches them as pending.
- Gates the pending bits with a software mask and drives the CPU's interrupt_0..3 inputs.
- Consumes the CPU's interrupt_N_clr acknowledges. Software configures and inspects it through the CPU data-memory/IO bus in the IO page (address high byte 8'h10).

---
 rtl/irq_ctrl_pkg.sv | 14 +
 rtl/irq_sync_edge.sv | 36 +++
 rtl/irq_ctrl.sv | 115 +++++++++++
 tb/tb_irq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the irq_ctrl interrupt controller: IO page, register
// offsets and source count.
package irq_ctrl_pkg;

    localparam logic [7:0] IO_PAGE = 8'h10;
    localparam int         NUM_SRC = 4;

    localparam logic [2:0] REG_PEND = 3'd0;
    localparam logic [2:0] REG_MASK = 3'd1;
    localparam logic [2:0] REG_CLR  = 3'd2;
    localparam logic [2:0] REG_MODE = 3'd3;
    localparam logic [2:0] REG_OVR  = 3'd4;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous event source, plus a delayed
// copy of the synchronised level for rising-edge detection.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic src_in,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], src_in};
        s_d_d  = sync_q[SYNC_STAGES-1];
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // which is what makes the shift chain a chain rather than a wire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~s_d_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronises four sources, latches them
// as pending, masks them onto interrupt_0..3. Overrun flags via IRQ_OVERRUN_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = 8'h40,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_address,
    input  logic [7:0]  io_din,
    input  logic        io_write_en,
    input  logic        io_read_en,
    output logic [7:0]  io_dout,
    input  logic [3:0]  src_in,
    output logic        interrupt_0,
    output logic        interrupt_1,
    output logic        interrupt_2,
    output logic        interrupt_3,
    input  logic        interrupt_0_clr,
    input  logic        interrupt_1_clr,
    input  logic        interrupt_2_clr,
    input  logic        interrupt_3_clr
);

    logic               hit, wr_hit, rd_hit;
    logic [2:0]         off;
    logic [NUM_SRC-1:0] s_lvl, s_rise, set_v, clr_v, irq_clr, rdata;
    logic [NUM_SRC-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
    logic [7:0]         dout_q, dout_d;
    logic [3:0]         unused_din;

    assign unused_din = io_din[7:4];

    assign hit    = (io_address[15:8] == IO_PAGE) && (io_address[7:3] == BASE_ADDR[7:3]);
    assign off    = io_address[2:0];
    assign wr_hit = io_write_en & hit;
    assign rd_hit = io_read_en & hit;

    assign irq_clr = {interrupt_3_clr, interrupt_2_clr, interrupt_1_clr, interrupt_0_clr};

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .reset   (reset),
            .src_in  (src_in[n]),
            .level_o (s_lvl[n]),
            .rise_o  (s_rise[n])
        );
    end

`ifdef IRQ_OVERRUN_EN
    logic [NUM_SRC-1:0] ovr_q, ovr_d;

    // An edge landing on an already-pending edge-mode source is lost; remember it.
    always_comb begin
        ovr_d = ovr_q;
        if (wr_hit && off == REG_OVR) ovr_d = ovr_q & ~io_din[NUM_SRC-1:0];
        ovr_d = ovr_d | (set_v & pend_q & mode_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovr_q <= '0;
        else        ovr_q <= ovr_d;
    end
`endif

    // NOTE: every variable gets a default before any conditional update, so no
    // path through this block leaves a value held and no latch is inferred.
    always_comb begin
        set_v = (mode_q & s_rise) | (~mode_q & s_lvl);
        clr_v = irq_clr;
        if (wr_hit && off == REG_CLR) clr_v = clr_v | io_din[NUM_SRC-1:0];
        pend_d = set_v | (pend_q & ~clr_v);

        mask_d = mask_q;
        mode_d = mode_q;
        if (wr_hit && off == REG_MASK) mask_d = io_din[NUM_SRC-1:0];
        if (wr_hit && off == REG_MODE) mode_d = io_din[NUM_SRC-1:0];

        rdata = '0;
        case (off)
            REG_PEND: rdata = pend_q;
            REG_MASK: rdata = mask_q;
            REG_MODE: rdata = mode_q;
`ifdef IRQ_OVERRUN_EN
            REG_OVR:  rdata = ovr_q;
`endif
            default:  rdata = '0;
        endcase
        dout_d = rd_hit ? {4'h0, rdata} : dout_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
            dout_q <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            dout_q <= dout_d;
        end
    end

    assign io_dout     = dout_q;
    assign interrupt_0 = pend_q[0] & mask_q[0];
    assign interrupt_1 = pend_q[1] & mask_q[1];
    assign interrupt_2 = pend_q[2] & mask_q[2];
    assign interrupt_3 = pend_q[3] & mask_q[3];

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register-access vector table plus directed
// multi-cycle sequences for latency, collision, masking, overrun and reset.
module tb_irq_ctrl;

    localparam logic [7:0] BASE = 8'h40;
`ifdef IRQ_OVERRUN_EN
    localparam logic [7:0] OVR_EXP = 8'h01;
`else
    localparam logic [7:0] OVR_EXP = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] io_address;
    logic [7:0]  io_din;
    logic        io_write_en, io_read_en;
    logic [7:0]  io_dout;
    logic [3:0]  src_in;
    logic [3:0]  irq_clr;
    logic        interrupt_0, interrupt_1, interrupt_2, interrupt_3;
    logic [3:0]  irq;
    logic [7:0]  rd;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [7:0]  din;
        logic        chk_dout;
        logic [7:0]  exp_dout;
        logic [3:0]  exp_irq;
        string       name;
    } vec_t;

    vec_t vecs[$];

    assign irq = {interrupt_3, interrupt_2, interrupt_1, interrupt_0};

    irq_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .io_address      (io_address),
        .io_din          (io_din),
        .io_write_en     (io_write_en),
        .io_read_en      (io_read_en),
        .io_dout         (io_dout),
        .src_in          (src_in),
        .interrupt_0     (interrupt_0),
        .interrupt_1     (interrupt_1),
        .interrupt_2     (interrupt_2),
        .interrupt_3     (interrupt_3),
        .interrupt_0_clr (irq_clr[0]),
        .interrupt_1_clr (irq_clr[1]),
        .interrupt_2_clr (irq_clr[2]),
        .interrupt_3_clr (irq_clr[3])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ra(input logic [2:0] off);
        return {8'h10, BASE[7:3], off};
    endfunction

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        io_address  = addr;
        io_din      = data;
        io_write_en = 1'b1;
        tick();
        io_write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
        io_address = addr;
        io_read_en = 1'b1;
        tick();
        io_read_en = 1'b0;
        data = io_dout;
    endtask

    task automatic pulse_src(input int n);
        src_in[n] = 1'b1;
        tick();
        src_in[n] = 1'b0;
    endtask

    task automatic pulse_clr(input int n);
        irq_clr[n] = 1'b1;
        tick();
        irq_clr[n] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        io_address  = 16'h0000;
        io_din      = 8'h00;
        io_write_en = 1'b0;
        io_read_en  = 1'b0;
        src_in      = 4'hF;
        irq_clr     = 4'h0;

        // ---------------- reset and defaults ----------------
        tick(3);
        check("rst_irq", {4'h0, irq}, 8'h00);
        check("rst_dout", io_dout, 8'h00);
        reset = 1'b1;
        bus_read(ra(3'd0), rd); check("rst_pend_rd", rd, 8'h00);
        bus_read(ra(3'd1), rd); check("rst_mask_rd", rd, 8'h00);
        bus_read(ra(3'd2), rd); check("rst_clr_rd", rd, 8'h00);
        bus_read(ra(3'd3), rd); check("rst_mode_rd", rd, 8'h00);
        bus_read(ra(3'd4), rd); check("rst_ovr_rd", rd, 8'h00);
        bus_read(ra(3'd0), rd); check("rst_level_pend", rd, 8'h0F);
        check("rst_masked_irq", {4'h0, irq}, 8'h00);
        src_in = 4'h0;
        tick(3);
        bus_write(ra(3'd2), 8'h0F);
        bus_read(ra(3'd0), rd); check("rst_pend_cleared", rd, 8'h00);

        // ---------------- register-access vector table ----------------
        vecs.push_back('{1'b1, 1'b0, 16'h1041, 8'hA5, 1'b0, 8'h00, 4'h0, "wr_mask"});
        vecs.push_back('{1'b0, 1'b1, 16'h1041, 8'h00, 1'b1, 8'h05, 4'h0, "rd_mask"});
        vecs.push_back('{1'b1, 1'b0, 16'h1043, 8'hFF, 1'b0, 8'h00, 4'h0, "wr_mode"});
        vecs.push_back('{1'b0, 1'b1, 16'h1043, 8'h00, 1'b1, 8'h0F, 4'h0, "rd_mode"});
        vecs.push_back('{1'b1, 1'b0, 16'h2041, 8'h00, 1'b0, 8'h00, 4'h0, "wr_page_miss"});
        vecs.push_back('{1'b0, 1'b1, 16'h1041, 8'h00, 1'b1, 8'h05, 4'h0, "page_miss_ignored"});
        vecs.push_back('{1'b1, 1'b0, 16'h1049, 8'h00, 1'b0, 8'h00, 4'h0, "wr_low_miss"});
        vecs.push_back('{1'b0, 1'b1, 16'h1041, 8'h00, 1'b1, 8'h05, 4'h0, "low_miss_ignored"});
        vecs.push_back('{1'b0, 1'b1, 16'h1045, 8'h00, 1'b1, 8'h00, 4'h0, "rd_off5"});
        vecs.push_back('{1'b0, 1'b1, 16'h1041, 8'h00, 1'b1, 8'h05, 4'h0, "rd_mask_again"});
        vecs.push_back('{1'b0, 1'b1, 16'h1145, 8'h00, 1'b1, 8'h05, 4'h0, "rd_miss_hold"});
        vecs.push_back('{1'b0, 1'b1, 16'h104D, 8'h00, 1'b1, 8'h05, 4'h0, "rd_low_miss_hold"});
        vecs.push_back('{1'b1, 1'b0, 16'h1045, 8'hFF, 1'b0, 8'h00, 4'h0, "wr_off5"});
        vecs.push_back('{1'b0, 1'b1, 16'h1045, 8'h00, 1'b1, 8'h00, 4'h0, "off5_wr_ignored"});
        vecs.push_back('{1'b1, 1'b0, 16'h1040, 8'hFF, 1'b0, 8'h00, 4'h0, "wr_pend"});
        vecs.push_back('{1'b0, 1'b1, 16'h1040, 8'h00, 1'b1, 8'h00, 4'h0, "pend_read_only"});
        vecs.push_back('{1'b1, 1'b0, 16'h1042, 8'hFF, 1'b0, 8'h00, 4'h0, "wr_clr"});
        vecs.push_back('{1'b0, 1'b1, 16'h1042, 8'h00, 1'b1, 8'h00, 4'h0, "clr_reads_zero"});
        vecs.push_back('{1'b0, 1'b1, 16'h1044, 8'h00, 1'b1, 8'h00, 4'h0, "ovr_reads_zero"});
        vecs.push_back('{1'b1, 1'b1, 16'h1041, 8'h0A, 1'b1, 8'h05, 4'h0, "rw_same_cycle_old"});
        vecs.push_back('{1'b0, 1'b1, 16'h1041, 8'h00, 1'b1, 8'h0A, 4'h0, "rw_write_done"});
        vecs.push_back('{1'b1, 1'b0, 16'h1043, 8'h00, 1'b0, 8'h00, 4'h0, "wr_mode_0"});
        vecs.push_back('{1'b1, 1'b0, 16'h1041, 8'h00, 1'b0, 8'h00, 4'h0, "wr_mask_0"});
        vecs.push_back('{1'b0, 1'b1, 16'h1043, 8'h00, 1'b1, 8'h00, 4'h0, "rd_mode_0"});
        vecs.push_back('{1'b0, 1'b1, 16'h1041, 8'h00, 1'b1, 8'h00, 4'h0, "rd_mask_0"});

        foreach (vecs[i]) begin
            io_address  = vecs[i].addr;
            io_din      = vecs[i].din;
            io_write_en = vecs[i].we;
            io_read_en  = vecs[i].re;
            tick();
            io_write_en = 1'b0;
            io_read_en  = 1'b0;
            if (vecs[i].chk_dout) check(vecs[i].name, io_dout, vecs[i].exp_dout);
            check({vecs[i].name, "_irq"}, {4'h0, irq}, {4'h0, vecs[i].exp_irq});
        end

        // ---------------- edge path latency ----------------
        bus_write(ra(3'd3), 8'h01);
        bus_write(ra(3'd1), 8'h01);
        pulse_src(0);
        check("edge_lat_1", {4'h0, irq}, 8'h00);
        tick();
        check("edge_lat_2", {4'h0, irq}, 8'h00);
        tick();
        check("edge_lat_3", {4'h0, irq}, 8'h01);
        tick();
        check("edge_hold", {4'h0, irq}, 8'h01);
        pulse_clr(0);
        check("edge_ack_irq", {4'h0, irq}, 8'h00);
        bus_read(ra(3'd0), rd); check("edge_ack_pend", rd, 8'h00);

        // ---------------- level path ----------------
        bus_write(ra(3'd3), 8'h00);
        bus_write(ra(3'd1), 8'h04);
        src_in[2] = 1'b1;
        tick(4);
        check("level_irq", {4'h0, irq}, 8'h04);
        bus_write(ra(3'd2), 8'h04);
        check("level_clr_held_irq", {4'h0, irq}, 8'h04);
        bus_read(ra(3'd0), rd); check("level_clr_held_pend", rd, 8'h04);
        src_in[2] = 1'b0;
        tick(3);
        bus_write(ra(3'd2), 8'h04);
        bus_read(ra(3'd0), rd); check("level_cleared_pend", rd, 8'h00);
        check("level_cleared_irq", {4'h0, irq}, 8'h00);

        // ---------------- set/clear collision ----------------
        bus_write(ra(3'd3), 8'h02);
        bus_write(ra(3'd1), 8'h02);
        src_in[1] = 1'b1;
        tick();
        src_in[1] = 1'b0;
        tick();
        pulse_clr(1);
        check("collide_irq", {4'h0, irq}, 8'h02);
        tick();
        check("collide_irq_hold", {4'h0, irq}, 8'h02);
        bus_read(ra(3'd0), rd); check("collide_pend", rd, 8'h02);
        pulse_clr(1);
        check("collide_ack", {4'h0, irq}, 8'h00);

        // ---------------- masked source still latches ----------------
        bus_write(ra(3'd1), 8'h00);
        bus_write(ra(3'd3), 8'h08);
        pulse_src(3);
        tick(4);
        check("masked_irq", {4'h0, irq}, 8'h00);
        bus_read(ra(3'd0), rd); check("masked_pend", rd, 8'h08);
        bus_write(ra(3'd1), 8'h08);
        check("unmask_irq", {4'h0, irq}, 8'h08);
        bus_write(ra(3'd2), 8'h08);
        check("unmask_clr_irq", {4'h0, irq}, 8'h00);

        // ---------------- overrun ----------------
        bus_write(ra(3'd3), 8'h01);
        bus_write(ra(3'd1), 8'h01);
        pulse_src(0);
        tick(4);
        check("ovr_first_irq", {4'h0, irq}, 8'h01);
        bus_read(ra(3'd4), rd); check("ovr_first_none", rd, 8'h00);
        pulse_src(0);
        tick(4);
        bus_read(ra(3'd4), rd); check("ovr_second", rd, OVR_EXP);
        bus_write(ra(3'd4), 8'h01);
        bus_read(ra(3'd4), rd); check("ovr_cleared", rd, 8'h00);
        bus_read(ra(3'd1), rd); check("pre_reset_mask", rd, 8'h01);
        check("pre_reset_irq", {4'h0, irq}, 8'h01);

        // ---------------- asynchronous reset mid-operation ----------------
        #2 reset = 1'b0;
        #1;
        check("async_rst_irq", {4'h0, irq}, 8'h00);
        check("async_rst_dout", io_dout, 8'h00);
        tick(2);
        reset = 1'b1;
        bus_read(ra(3'd1), rd); check("post_rst_mask", rd, 8'h00);
        bus_read(ra(3'd0), rd); check("post_rst_pend", rd, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
